// File: rtl/reg_file_swap_clr.sv
// General-purpose register bank: two combinational read ports, one WRITE/SWAP/MOVE
// command port, a sequenced clear engine with busy flag and optional write bypass.
module reg_file_swap_clr #(
    parameter int unsigned W      = 8,
    parameter int unsigned AW     = 4,
    parameter int unsigned BYPASS = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    op,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  dat_in,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    input  logic          clr_req,
    output logic [W-1:0]  datA_out,
    output logic [W-1:0]  datB_out,
    output logic          busy,
    output logic          drop
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_SWAP  = 2'd2,
        OP_MOVE  = 2'd3
    } op_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [W-1:0]  core [DEPTH];

    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                CLEAR: begin
                    core[ptr] <= '0;
                    ptr       <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= IDLE;
                    end
                    if (op_t'(op) != OP_NOP) begin
                        drop <= 1'b1;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        drop  <= (op_t'(op) != OP_NOP);
                    end else begin
                        // Non-blocking reads give the pre-edge values, so SWAP is atomic
                        // and a self-swap or self-move rewrites the same value.
                        case (op_t'(op))
                            OP_WRITE: core[wr_addr] <= dat_in;
                            OP_SWAP: begin
                                core[rd_addrA] <= core[rd_addrB];
                                core[rd_addrB] <= core[rd_addrA];
                            end
                            OP_MOVE:  core[wr_addr] <= core[rd_addrA];
                            default:  ;
                        endcase
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_comb begin
        datA_out = core[rd_addrA];
        datB_out = core[rd_addrB];
        if (busy) begin
            datA_out = '0;
            datB_out = '0;
        end else if (BYPASS != 0 && op_t'(op) == OP_WRITE) begin
            if (rd_addrA == wr_addr) begin
                datA_out = dat_in;
            end
            if (rd_addrB == wr_addr) begin
                datB_out = dat_in;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_swap_clr.sv
// Directed bench for reg_file_swap_clr: one unbypassed and one bypassed instance
// driven from the same stimulus, checked against hand-computed vectors.
module tb_reg_file_swap_clr;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [3:0] wr_addr, rd_addrA, rd_addrB;
    logic [7:0] dat_in;
    logic       clr_req;
    logic [7:0] a0, b0, a1, b1;
    logic       busy0, busy1, drop0, drop1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_swap_clr #(.W(8), .AW(4), .BYPASS(0)) u_dut0 (
        .clk(clk), .reset(reset), .op(op), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .clr_req(clr_req),
        .datA_out(a0), .datB_out(b0), .busy(busy0), .drop(drop0)
    );

    reg_file_swap_clr #(.W(8), .AW(4), .BYPASS(1)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .clr_req(clr_req),
        .datA_out(a1), .datB_out(b1), .busy(busy1), .drop(drop1)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] wa;
        logic [7:0] din;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea0, eb0, ea1, eb1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] o, input logic [3:0] wa, input logic [7:0] d,
                          input logic [3:0] ra, input logic [3:0] rb, input logic c);
        op = o; wr_addr = wa; dat_in = d; rd_addrA = ra; rd_addrB = rb; clr_req = c;
    endtask

    initial begin
        int  cnt;
        bit  done;
        bit  drop_seen;

        //            op    wa     din    ra     rb     A0     B0     A1     B1
        tbl[0]  = '{2'd1, 4'd3, 8'hA5, 4'd3, 4'd7, 8'h00, 8'h00, 8'hA5, 8'h00};
        tbl[1]  = '{2'd1, 4'd7, 8'h3C, 4'd3, 4'd7, 8'hA5, 8'h00, 8'hA5, 8'h3C};
        tbl[2]  = '{2'd0, 4'd0, 8'h00, 4'd3, 4'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tbl[3]  = '{2'd2, 4'd0, 8'h00, 4'd3, 4'd7, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tbl[4]  = '{2'd0, 4'd0, 8'h00, 4'd3, 4'd7, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        tbl[5]  = '{2'd2, 4'd0, 8'h00, 4'd3, 4'd3, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        tbl[6]  = '{2'd0, 4'd0, 8'h00, 4'd3, 4'd7, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        tbl[7]  = '{2'd3, 4'd9, 8'h00, 4'd7, 4'd9, 8'hA5, 8'h00, 8'hA5, 8'h00};
        tbl[8]  = '{2'd0, 4'd0, 8'h00, 4'd9, 4'd7, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[9]  = '{2'd3, 4'd9, 8'h00, 4'd9, 4'd9, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tbl[10] = '{2'd0, 4'd0, 8'h00, 4'd9, 4'd3, 8'hA5, 8'h3C, 8'hA5, 8'h3C};

        // Reset held 3 cycles, then the clear sequence
        reset = 1'b1;
        set_in(2'd0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy0}, 32'd1);
        chk("reset_drop", {31'd0, drop0}, 32'd0);
        chk("reset_readA_forced0", {24'd0, a0}, 32'd0);
        next_cycle();
        cnt = 1; done = 0; drop_seen = 0;
        for (int c = 2; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (busy0) cnt++; else done = 1;
            if (drop0 || drop1) drop_seen = 1;
            next_cycle();
        end
        chk("init_busy_cycles", cnt, 32'd16);
        chk("init_drop_quiet", {31'd0, drop_seen}, 32'd0);
        chk("init_busy_bypass_inst", {31'd0, busy1}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            set_in(2'd0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0);
            @(negedge clk);
            chk("init_zero_A0", {24'd0, a0}, 32'd0);
            chk("init_zero_B0", {24'd0, b0}, 32'd0);
            chk("init_zero_A1", {24'd0, a1}, 32'd0);
            chk("init_zero_B1", {24'd0, b1}, 32'd0);
            next_cycle();
        end

        // Write / swap / move vectors; reads sampled before the edge that applies op
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].op, tbl[i].wa, tbl[i].din, tbl[i].ra, tbl[i].rb, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_A0", i), {24'd0, a0}, {24'd0, tbl[i].ea0});
            chk($sformatf("vec%0d_B0", i), {24'd0, b0}, {24'd0, tbl[i].eb0});
            chk($sformatf("vec%0d_A1", i), {24'd0, a1}, {24'd0, tbl[i].ea1});
            chk($sformatf("vec%0d_B1", i), {24'd0, b1}, {24'd0, tbl[i].eb1});
            chk($sformatf("vec%0d_drop", i), {30'd0, drop0, drop1}, 32'd0);
            next_cycle();
        end

        // clr_req with a same-cycle WRITE, then a WRITE at busy cycle 5
        set_in(2'd1, 4'd2, 8'h11, 4'd3, 4'd2, 1'b1);
        next_cycle();
        clr_req = 1'b0;
        cnt = 0; done = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            set_in((c == 5) ? 2'd1 : 2'd0, 4'd2, 8'h11, 4'd3, 4'd2, 1'b0);
            @(negedge clk);
            if (busy0) cnt++; else done = 1;
            if (c == 1) begin
                chk("clr_drop_pulse", {30'd0, drop0, drop1}, 32'd3);
                chk("clr_busy_read_forced0", {24'd0, a0}, 32'd0);
                chk("clr_busy_read_forced0_byp", {24'd0, a1}, 32'd0);
            end
            if (c == 2) chk("clr_drop_one_cycle", {31'd0, drop0}, 32'd0);
            if (c == 6) chk("busy_write_drop", {31'd0, drop0}, 32'd1);
            if (c == 7) chk("busy_write_drop_end", {31'd0, drop0}, 32'd0);
            next_cycle();
        end
        chk("clr_busy_cycles", cnt, 32'd16);
        set_in(2'd0, 4'd0, 8'h00, 4'd2, 4'd3, 1'b0);
        @(negedge clk);
        chk("clr_r2_zero", {24'd0, a0}, 32'd0);
        chk("clr_r3_zero", {24'd0, b0}, 32'd0);
        next_cycle();

        // Reset at clear cycle 8 restarts the sequence from entry 0
        set_in(2'd1, 4'd15, 8'hEE, 4'd15, 4'd0, 1'b0);
        next_cycle();
        set_in(2'd0, 4'd0, 8'h00, 4'd15, 4'd0, 1'b0);
        @(negedge clk);
        chk("pre_clear_r15", {24'd0, a0}, 32'h0EE);
        next_cycle();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        cnt = 0; done = 0;
        for (int c = 1; c <= 60 && !done; c++) begin
            reset = (c == 8);
            @(negedge clk);
            if (busy0) cnt++; else done = 1;
            next_cycle();
        end
        reset = 1'b0;
        chk("restart_busy_cycles", cnt, 32'd24);
        set_in(2'd0, 4'd0, 8'h00, 4'd15, 4'd7, 1'b0);
        @(negedge clk);
        chk("restart_r15_zero", {24'd0, a0}, 32'd0);
        chk("restart_r7_zero", {24'd0, b1}, 32'd0);
        chk("restart_drop", {30'd0, drop0, drop1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
